// File: rtl/registros_salida_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse report serializer.
package registros_salida_mouse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StS0,
    StW0,
    StS1,
    StW1,
    StS2,
    StW2
  } estado_e;

  // Bit position of the always-one marker in the first report byte.
  localparam int unsigned MOUSE_B0_SIEMPRE1 = 3;
  localparam int          MOUSE_DELTA_MAX   = 255;
  localparam int          MOUSE_DELTA_MIN   = -256;

  // One latched report; all three bytes are derived from this snapshot.
  typedef struct packed {
    logic       yovf;
    logic       xovf;
    logic [8:0] y;
    logic [8:0] x;
    logic [2:0] btn;
  } paquete_t;

  // First byte: {Yovf, Xovf, Ysign, Xsign, 1, buttons}.
  function automatic logic [7:0] byte0(input paquete_t p);
    logic [7:0] b;
    b                    = 8'h00;
    b[7]                 = p.yovf;
    b[6]                 = p.xovf;
    b[5]                 = p.y[8];
    b[4]                 = p.x[8];
    b[MOUSE_B0_SIEMPRE1] = 1'b1;
    b[2:0]               = p.btn;
    return b;
  endfunction

endpackage

// File: rtl/registros_salida_mouse_acumulador.sv
// Adds a 9-bit signed delta to a 10-bit signed running value, clamping the result to the
// report range and flagging when the true sum fell outside it.
module acumulador_saturado_mouse
  import registros_salida_mouse_pkg::*;
(
  input  logic [9:0] acum_i,
  input  logic [8:0] delta_i,
  output logic [9:0] suma_o,
  output logic       ovf_o
);

  localparam logic signed [10:0] LimMax = 11'(MOUSE_DELTA_MAX);
  localparam logic signed [10:0] LimMin = 11'(MOUSE_DELTA_MIN);

  logic signed [10:0] suma_ext;

  // Widen both operands so the true sum never wraps, then clamp.
  always_comb begin
    suma_ext = $signed({acum_i[9], acum_i}) + $signed({{2{delta_i[8]}}, delta_i});
    suma_o   = suma_ext[9:0];
    ovf_o    = 1'b0;
    if (suma_ext > LimMax) begin
      suma_o = LimMax[9:0];
      ovf_o  = 1'b1;
    end else if (suma_ext < LimMin) begin
      suma_o = LimMin[9:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/registros_salida_mouse.sv
// Serializes one mouse report into three PS/2 bytes with a start/done handshake.
// Optional feature macro: MOUSE_ACUM_EN (accumulate requests that arrive while busy).
module registros_salida_mouse
  import registros_salida_mouse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] XMouse,
  input  logic [8:0] YMouse,
  input  logic [2:0] Botones,
  input  logic       DatosValidos,
  output logic       Ocupado,
  output logic [7:0] ByteSaliente,
  output logic       TxIniciar,
  input  logic       TxListo,
  output logic       PaqueteEnviado
);

  estado_e  estado_q, estado_d;
  paquete_t paq_q, paq_d;
  logic     enviado_q, enviado_d;
  paquete_t nuevo;

  assign nuevo = '{yovf: 1'b0, xovf: 1'b0, y: YMouse, x: XMouse, btn: Botones};

`ifdef MOUSE_ACUM_EN
  logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [2:0] pend_btn_q, pend_btn_d;
  logic       pend_xovf_q, pend_xovf_d, pend_yovf_q, pend_yovf_d;
  logic       pend_v_q, pend_v_d;
  logic       fin, tomar, acumular;
  logic [9:0] base_x, base_y, suma_x, suma_y;
  logic       ovf_x, ovf_y;

  assign fin      = (estado_q == StW2) && TxListo;
  assign tomar    = fin && pend_v_q;
  // A request landing on the last done with nothing pending is launched directly instead.
  assign acumular = DatosValidos && Ocupado && !(fin && !pend_v_q);
  // When pending data is consumed this cycle, a coincident request starts from zero.
  assign base_x   = tomar ? 10'd0 : pend_x_q;
  assign base_y   = tomar ? 10'd0 : pend_y_q;

  acumulador_saturado_mouse u_acum_x (
    .acum_i (base_x),
    .delta_i(XMouse),
    .suma_o (suma_x),
    .ovf_o  (ovf_x)
  );

  acumulador_saturado_mouse u_acum_y (
    .acum_i (base_y),
    .delta_i(YMouse),
    .suma_o (suma_y),
    .ovf_o  (ovf_y)
  );

  // Pending set: cleared when taken into a packet, merged with each busy-time request.
  always_comb begin
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_btn_d  = pend_btn_q;
    pend_xovf_d = pend_xovf_q;
    pend_yovf_d = pend_yovf_q;
    pend_v_d    = pend_v_q;
    if (tomar) begin
      pend_x_d    = 10'd0;
      pend_y_d    = 10'd0;
      pend_btn_d  = 3'b000;
      pend_xovf_d = 1'b0;
      pend_yovf_d = 1'b0;
      pend_v_d    = 1'b0;
    end
    if (acumular) begin
      pend_x_d    = suma_x;
      pend_y_d    = suma_y;
      pend_btn_d  = (tomar ? 3'b000 : pend_btn_q) | Botones;
      pend_xovf_d = (tomar ? 1'b0 : pend_xovf_q) | ovf_x;
      pend_yovf_d = (tomar ? 1'b0 : pend_yovf_q) | ovf_y;
      pend_v_d    = 1'b1;
    end
  end

  // Pending-set registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_x_q    <= 10'd0;
      pend_y_q    <= 10'd0;
      pend_btn_q  <= 3'b000;
      pend_xovf_q <= 1'b0;
      pend_yovf_q <= 1'b0;
      pend_v_q    <= 1'b0;
    end else begin
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_btn_q  <= pend_btn_d;
      pend_xovf_q <= pend_xovf_d;
      pend_yovf_q <= pend_yovf_d;
      pend_v_q    <= pend_v_d;
    end
  end
`endif

  // Sequencer next state; the packet register only loads when a new packet begins.
  always_comb begin
    estado_d  = estado_q;
    paq_d     = paq_q;
    enviado_d = 1'b0;
    unique case (estado_q)
      StIdle: begin
        if (DatosValidos) begin
          paq_d    = nuevo;
          estado_d = StS0;
        end
      end
      StS0: estado_d = StW0;
      StW0: if (TxListo) estado_d = StS1;
      StS1: estado_d = StW1;
      StW1: if (TxListo) estado_d = StS2;
      StS2: estado_d = StW2;
      StW2: begin
        if (TxListo) begin
          enviado_d = 1'b1;
          estado_d  = StIdle;
`ifdef MOUSE_ACUM_EN
          if (pend_v_q) begin
            paq_d    = '{yovf: pend_yovf_q, xovf: pend_xovf_q, y: pend_y_q[8:0],
                         x: pend_x_q[8:0], btn: pend_btn_q};
            estado_d = StS0;
          end else if (DatosValidos) begin
            paq_d    = nuevo;
            estado_d = StS0;
          end
`endif
        end
      end
      default: estado_d = StIdle;
    endcase
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    Ocupado      = (estado_q != StIdle);
    TxIniciar    = (estado_q == StS0) || (estado_q == StS1) || (estado_q == StS2);
    ByteSaliente = 8'h00;
    unique case (estado_q)
      StS0, StW0: ByteSaliente = byte0(paq_q);
      StS1, StW1: ByteSaliente = paq_q.x[7:0];
      StS2, StW2: ByteSaliente = paq_q.y[7:0];
      default:    ByteSaliente = 8'h00;
    endcase
  end

  assign PaqueteEnviado = enviado_q;

  // State, packet snapshot and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= StIdle;
      paq_q     <= '0;
      enviado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      paq_q     <= paq_d;
      enviado_q <= enviado_d;
    end
  end

endmodule

// File: tb/tb_registros_salida_mouse.sv
// Scoreboard bench: stimulus pushes expected reports, a transmitter/monitor process
// reassembles bytes (receive-side decode) and compares.
module tb_registros_salida_mouse;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] XMouse, YMouse;
  logic [2:0] Botones;
  logic       DatosValidos;
  logic       Ocupado;
  logic [7:0] ByteSaliente;
  logic       TxIniciar;
  logic       TxListo = 1'b0;
  logic       PaqueteEnviado;

  registros_salida_mouse dut (
    .clk           (clk),
    .rst           (rst),
    .XMouse        (XMouse),
    .YMouse        (YMouse),
    .Botones       (Botones),
    .DatosValidos  (DatosValidos),
    .Ocupado       (Ocupado),
    .ByteSaliente  (ByteSaliente),
    .TxIniciar     (TxIniciar),
    .TxListo       (TxListo),
    .PaqueteEnviado(PaqueteEnviado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] x, y;
    logic [2:0] btn;
  } exp_t;

  exp_t cola[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, act, req, $time);
    end
  endtask

  // Reference: report fields to wire bytes.
  function automatic exp_t modelo(input logic [8:0] x, input logic [8:0] y,
                                  input logic [2:0] b, input logic xo, input logic yo);
    exp_t e;
    e.b0  = {yo, xo, y[8], x[8], 1'b1, b};
    e.b1  = x[7:0];
    e.b2  = y[7:0];
    e.x   = x;
    e.y   = y;
    e.btn = b;
    return e;
  endfunction

  function automatic int satura(input int s);
    if (s > 255) return 255;
    if (s < -256) return -256;
    return s;
  endfunction

  // Transmitter model and monitor.
  int         lat_fijo = -1;
  bit         spur_en = 1'b0;
  bit         tx_busy = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] cap[3];
  int         bidx = 0;
  logic [7:0] byte_act = 8'h00;
  bit         expect_pe = 1'b0;
  int         n_pe = 0, n_paq = 0, n_starts = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      TxListo   = 1'b0;
      tx_busy   = 1'b0;
      bidx      = 0;
      expect_pe = 1'b0;
    end else begin
      if (expect_pe || PaqueteEnviado === 1'b1) begin
        chk("paquete_enviado", 32'(PaqueteEnviado), 32'(expect_pe));
`ifndef MOUSE_ACUM_EN
        if (PaqueteEnviado === 1'b1) chk("ocupado_tras_fin", 32'(Ocupado), 32'd0);
`endif
        if (PaqueteEnviado === 1'b1) n_pe++;
        expect_pe = 1'b0;
      end
      TxListo = 1'b0;
      if (tx_busy) begin
        if (TxIniciar !== 1'b0) chk("inicio_en_vuelo", 32'(TxIniciar), 32'd0);
        if (tx_cnt == 0) begin
          chk("byte_sostenido", 32'(ByteSaliente), 32'(byte_act));
          TxListo = 1'b1;
          tx_busy = 1'b0;
          if (bidx == 3) begin
            expect_pe = 1'b1;
            bidx      = 0;
          end
        end else begin
          tx_cnt--;
        end
      end else if (TxIniciar === 1'b1) begin
        n_starts++;
        chk("ocupado_en_inicio", 32'(Ocupado), 32'd1);
        byte_act  = ByteSaliente;
        cap[bidx] = ByteSaliente;
        bidx++;
        tx_busy = 1'b1;
        tx_cnt  = (lat_fijo >= 0) ? lat_fijo : int'($urandom_range(0, 10));
        // A done in the start cycle must be ignored.
        if (spur_en && $urandom_range(0, 3) == 0) TxListo = 1'b1;
        if (bidx == 3) begin
          if (cola.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL paquete_inesperado: got %h %h %h expected none",
                     cap[0], cap[1], cap[2]);
          end else begin
            e = cola.pop_front();
            chk("byte0", 32'(cap[0]), 32'(e.b0));
            chk("byte1", 32'(cap[1]), 32'(e.b1));
            chk("byte2", 32'(cap[2]), 32'(e.b2));
            chk("lazo_x", 32'({cap[0][4], cap[1]}), 32'(e.x));
            chk("lazo_y", 32'({cap[0][5], cap[2]}), 32'(e.y));
            chk("lazo_btn", 32'(cap[0][2:0]), 32'(e.btn));
            n_paq++;
          end
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        TxListo = 1'b1;  // stray done while idle
      end
    end
  end

  // Called at a negedge; leaves inputs set for one sampling edge.
  task automatic pulso_dv(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    XMouse       = x;
    YMouse       = y;
    Botones      = b;
    DatosValidos = 1'b1;
    @(negedge clk);
    DatosValidos = 1'b0;
  endtask

  task automatic lanzar(input exp_t e);
    cola.push_back(e);
    pulso_dv(e.x, e.y, e.btn);
    chk("ocupado_k1", 32'(Ocupado), 32'd1);
    chk("txiniciar_k1", 32'(TxIniciar), 32'd1);
  endtask

  task automatic esperar_fin();
    int n = 0;
    while (PaqueteEnviado !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("timeout_fin", 32'(PaqueteEnviado), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   s0;
    int   n;
    int   xs, ys;
    rst          = 1'b1;
    DatosValidos = 1'b0;
    XMouse       = 9'h000;
    YMouse       = 9'h000;
    Botones      = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_ocupado", 32'(Ocupado), 32'd0);
    chk("rst_byte", 32'(ByteSaliente), 32'd0);
    chk("rst_txiniciar", 32'(TxIniciar), 32'd0);
    chk("rst_enviado", 32'(PaqueteEnviado), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed report with fixed 10-cycle transmitter and stray dones.
    lat_fijo = 9;
    spur_en  = 1'b1;
    e.b0 = 8'h29; e.b1 = 8'h05; e.b2 = 8'hFD;
    e.x = 9'h005; e.y = 9'h1FD; e.btn = 3'b001;
    lanzar(e);
`ifndef MOUSE_ACUM_EN
    pulso_dv(9'h0AA, 9'h055, 3'b111);  // busy: must be dropped
`endif
    esperar_fin();

    // Random reports, random latency and gaps (gap 0 = request in the done-pulse cycle).
    lat_fijo = -1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      lanzar(modelo(9'($urandom), 9'($urandom), 3'($urandom), 1'b0, 1'b0));
`ifndef MOUSE_ACUM_EN
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulso_dv(9'($urandom), 9'($urandom), 3'($urandom));
      end
`endif
      esperar_fin();
    end

`ifdef MOUSE_ACUM_EN
    // Busy-time requests merge: X saturates, Y sums, buttons OR.
    lat_fijo = 9;
    @(negedge clk);
    lanzar(modelo(9'h010, 9'h020, 3'b100, 1'b0, 1'b0));
    @(negedge clk);
    pulso_dv(9'd200, 9'h000, 3'b010);
    pulso_dv(9'd200, 9'h1F6, 3'b000);
    xs = satura(200 + 200);
    ys = satura(0 - 10);
    cola.push_back(modelo(9'(xs), 9'(ys), 3'b010, xs != 400, ys != -10));
    esperar_fin();
    chk("sin_hueco", 32'(TxIniciar), 32'd1);
    @(negedge clk);
    esperar_fin();
`endif

    // Reset while waiting on the second byte.
    lat_fijo = 9;
    repeat (2) @(negedge clk);
    s0 = n_starts;
    lanzar(modelo(9'h123, 9'h0F0, 3'b101, 1'b0, 1'b0));
    n = 0;
    while (n_starts < s0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("llega_w1", 32'(n_starts - s0), 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw1_ocupado", 32'(Ocupado), 32'd0);
    chk("rstw1_byte", 32'(ByteSaliente), 32'd0);
    chk("rstw1_txiniciar", 32'(TxIniciar), 32'd0);
    chk("rstw1_enviado", 32'(PaqueteEnviado), 32'd0);
    cola.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0  = n_starts;
    repeat (30) @(negedge clk);
    chk("sin_reenvio", 32'(n_starts - s0), 32'd0);

    // Normal operation resumes after reset.
    lat_fijo = -1;
    lanzar(modelo(9'h1FF, 9'h001, 3'b110, 1'b0, 1'b0));
    esperar_fin();
    repeat (3) @(negedge clk);

    chk("cola_vacia", 32'(cola.size()), 32'd0);
    chk("pulsos_vs_paquetes", 32'(n_pe), 32'(n_paq));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
